// File: rtl/mc3999_pkg.sv
// Shared types and constants for the MC3999 execute stage.
package mc3999_pkg;

  localparam int VAL_MAX = 999;
  localparam int VAL_MIN = -999;

  localparam logic [2:0] ADDR_ACC = 3'b000;
  localparam logic [2:0] ADDR_P0  = 3'b010;
  localparam logic [2:0] ADDR_P1  = 3'b011;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_MOV = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_MUL = 4'd4,
    OP_NOT = 4'd5,
    OP_TEQ = 4'd6,
    OP_TGT = 4'd7,
    OP_TLT = 4'd8,
    OP_TCP = 4'd9,
    OP_SLP = 4'd10
  } opcode_e;

  typedef enum logic [1:0] {
    CND_ALWAYS = 2'b00,
    CND_PLUS   = 2'b01,
    CND_MINUS  = 2'b10,
    CND_RSVD   = 2'b11
  } cond_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SLEEP = 1'b1
  } state_e;

endpackage

// File: rtl/mc3999_sat.sv
// Signed clamp of a wide intermediate result into the game value range.
module mc3999_sat
  import mc3999_pkg::*;
#(
  parameter int unsigned IW = 22,
  parameter int unsigned OW = 11
) (
  input  logic signed [IW-1:0] din,
  output logic        [OW-1:0] dout
);

  localparam logic signed [IW-1:0] MAX_V = IW'(VAL_MAX);
  localparam logic signed [IW-1:0] MIN_V = IW'(VAL_MIN);

  always_comb begin
    dout = din[OW-1:0];
    if (din > MAX_V) begin
      dout = OW'(MAX_V);
    end else if (din < MIN_V) begin
      dout = OW'(MIN_V);
    end
  end

endmodule

// File: rtl/mc3999_exec.sv
// MC3999 execute stage: saturating ALU, test flags, conditional issue and tick-counted sleep.
module mc3999_exec
  import mc3999_pkg::*;
#(
  parameter int unsigned DW    = 11,
  parameter int unsigned SLP_W = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [3:0]    opcode,
  input  logic [1:0]    cond,
  input  logic [2:0]    dst_addr,
  input  logic [DW-1:0] src0,
  input  logic [DW-1:0] src1,
  output logic [DW-1:0] write_dat,
  output logic [2:0]    write_addr,
  output logic          write_en,
  output logic          flag_plus,
  output logic          flag_minus,
  output logic          sleeping
);

  localparam int unsigned SUM_W  = DW + 1;
  localparam int unsigned PROD_W = 2 * DW;

  state_e               state_q, state_d;
  logic [SLP_W-1:0]     cnt_q, cnt_d;
  logic                 wr_en_q, wr_en_d;
  logic [DW-1:0]        wr_dat_q, wr_dat_d;
  logic [2:0]           wr_addr_q, wr_addr_d;
  logic                 flag_plus_q, flag_plus_d;
  logic                 flag_minus_q, flag_minus_d;

  logic signed [DW-1:0]     src0_s, src1_s;
  logic signed [SUM_W-1:0]  sum_w, diff_w;
  logic signed [PROD_W-1:0] prod_w, arith_w;
  logic [DW-1:0]            sat_out;
  logic                     cond_ok, accept_c, exec_c;

  assign src0_s = signed'(src0);
  assign src1_s = signed'(src1);
  assign sum_w  = SUM_W'(src1_s) + SUM_W'(src0_s);
  assign diff_w = SUM_W'(src1_s) - SUM_W'(src0_s);
  assign prod_w = PROD_W'(src1_s) * PROD_W'(src0_s);

  // Single clamp on the muxed full-width arithmetic result.
  always_comb begin
    arith_w = PROD_W'(sum_w);
    case (opcode)
      OP_SUB:  arith_w = PROD_W'(diff_w);
      OP_MUL:  arith_w = prod_w;
      default: arith_w = PROD_W'(sum_w);
    endcase
  end

  mc3999_sat #(.IW(PROD_W), .OW(DW)) u_sat (
    .din  (arith_w),
    .dout (sat_out)
  );

  always_comb begin
    cond_ok = 1'b1;
    case (cond)
      CND_PLUS:  cond_ok = flag_plus_q;
      CND_MINUS: cond_ok = flag_minus_q;
      default:   cond_ok = 1'b1;
    endcase
  end

  assign accept_c = issue_valid & issue_ready;
  assign exec_c   = accept_c & cond_ok;

  // Write port and test flags; skipped instructions leave everything untouched.
  always_comb begin
    wr_en_d      = 1'b0;
    wr_dat_d     = wr_dat_q;
    wr_addr_d    = wr_addr_q;
    flag_plus_d  = flag_plus_q;
    flag_minus_d = flag_minus_q;
    if (exec_c) begin
      case (opcode)
        OP_MOV: begin
          wr_en_d   = 1'b1;
          wr_dat_d  = src0;
          wr_addr_d = dst_addr;
        end
        OP_ADD, OP_SUB, OP_MUL: begin
          wr_en_d   = 1'b1;
          wr_dat_d  = sat_out;
          wr_addr_d = ADDR_ACC;
        end
        OP_NOT: begin
          wr_en_d   = 1'b1;
          wr_dat_d  = (src1 == '0) ? DW'(100) : '0;
          wr_addr_d = ADDR_ACC;
        end
        OP_TEQ: begin
          flag_plus_d  = (src0_s == src1_s);
          flag_minus_d = (src0_s != src1_s);
        end
        OP_TGT: begin
          flag_plus_d  = (src0_s > src1_s);
          flag_minus_d = !(src0_s > src1_s);
        end
        OP_TLT: begin
          flag_plus_d  = (src0_s < src1_s);
          flag_minus_d = !(src0_s < src1_s);
        end
        OP_TCP: begin
          flag_plus_d  = (src0_s > src1_s);
          flag_minus_d = (src0_s < src1_s);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sleep entry only for an executed SLP with a positive count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (exec_c && (opcode == OP_SLP) && (src0_s > 0)) begin
          state_d = ST_SLEEP;
          cnt_d   = src0[SLP_W-1:0];
        end
      end
      ST_SLEEP: begin
        if (tick) begin
          if (cnt_q == SLP_W'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - SLP_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    issue_ready = 1'b0;
    sleeping    = 1'b0;
    case (state_q)
      ST_IDLE:  issue_ready = 1'b1;
      ST_SLEEP: sleeping    = 1'b1;
      default:  issue_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q      <= 1'b0;
      wr_dat_q     <= '0;
      wr_addr_q    <= ADDR_ACC;
      flag_plus_q  <= 1'b0;
      flag_minus_q <= 1'b0;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_dat_q     <= wr_dat_d;
      wr_addr_q    <= wr_addr_d;
      flag_plus_q  <= flag_plus_d;
      flag_minus_q <= flag_minus_d;
    end
  end

  assign write_en   = wr_en_q;
  assign write_dat  = wr_dat_q;
  assign write_addr = wr_addr_q;
  assign flag_plus  = flag_plus_q;
  assign flag_minus = flag_minus_q;

endmodule

// File: tb/tb_mc3999_exec.sv
// Scoreboard bench for mc3999_exec: directed instructions, queued write expectations.
module tb_mc3999_exec;
  import mc3999_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  opcode;
  logic [1:0]  cond;
  logic [2:0]  dst_addr;
  logic [10:0] src0;
  logic [10:0] src1;
  logic [10:0] write_dat;
  logic [2:0]  write_addr;
  logic        write_en;
  logic        flag_plus;
  logic        flag_minus;
  logic        sleeping;

  typedef struct packed {
    logic [10:0] dat;
    logic [2:0]  addr;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  errors = 0;
  int  checks = 0;

  mc3999_exec #(.DW(11), .SLP_W(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .opcode      (opcode),
    .cond        (cond),
    .dst_addr    (dst_addr),
    .src0        (src0),
    .src1        (src1),
    .write_dat   (write_dat),
    .write_addr  (write_addr),
    .write_en    (write_en),
    .flag_plus   (flag_plus),
    .flag_minus  (flag_minus),
    .sleeping    (sleeping)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input int dat, input logic [2:0] addr);
    wr_t e;
    e.dat  = 11'(dat);
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] cd, input logic [2:0] da,
                       input int s0, input int s1, input logic tk);
    @(negedge clk);
    opcode      = op;
    cond        = cd;
    dst_addr    = da;
    src0        = 11'(s0);
    src1        = 11'(s1);
    tick        = tk;
    issue_valid = 1'b1;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    tick        = 1'b0;
  endtask

  task automatic chk_flags(input string name, input logic p, input logic m);
    chk({name, "_plus"}, 32'(flag_plus), 32'(p));
    chk({name, "_minus"}, 32'(flag_minus), 32'(m));
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && write_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(1), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_dat", 32'(write_dat), 32'(mon_e.dat));
        chk("write_addr", 32'(write_addr), 32'(mon_e.addr));
      end
    end
  end

  initial begin
    rst_n = 1'b0; tick = 1'b0; issue_valid = 1'b0;
    opcode = '0; cond = '0; dst_addr = '0; src0 = '0; src1 = '0;
    #12;
    chk("rst_write_en", 32'(write_en), 32'(0));
    chk("rst_write_dat", 32'(write_dat), 32'(0));
    chk("rst_sleeping", 32'(sleeping), 32'(0));
    chk_flags("rst", 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(issue_ready), 32'(1));

    // Reset while sleeping
    issue(OP_SLP, 2'b00, 3'b000, 5, 0, 1'b0);
    chk("slp5_sleeping", 32'(sleeping), 32'(1));
    chk("slp5_ready", 32'(issue_ready), 32'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sleeping", 32'(sleeping), 32'(0));
    chk("midrst_write_en", 32'(write_en), 32'(0));
    chk("midrst_write_addr", 32'(write_addr), 32'(0));
    chk_flags("midrst", 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_ready", 32'(issue_ready), 32'(1));
    chk("postrst_sleeping", 32'(sleeping), 32'(0));
    chk("postrst_write_en", 32'(write_en), 32'(0));

    // Write-port ops, back to back
    push_wr(42, ADDR_P0);   issue(OP_MOV, 2'b00, 3'b010, 42, 0, 1'b0);
    push_wr(999, ADDR_ACC); issue(OP_ADD, 2'b00, 3'b101, 200, 900, 1'b0);
    push_wr(-999, ADDR_ACC); issue(OP_SUB, 2'b00, 3'b011, 500, -900, 1'b0);
    push_wr(-999, ADDR_ACC); issue(OP_MUL, 2'b00, 3'b000, 30, -40, 1'b0);
    push_wr(-84, ADDR_ACC); issue(OP_MUL, 2'b00, 3'b000, -7, 12, 1'b0);
    push_wr(100, ADDR_ACC); issue(OP_NOT, 2'b00, 3'b011, 9, 0, 1'b0);
    push_wr(0, ADDR_ACC);   issue(OP_NOT, 2'b00, 3'b000, 9, 5, 1'b0);

    // Flags and conditional execution
    issue(OP_TLT, 2'b00, 3'b000, 1, 2, 1'b0);
    chk_flags("tlt", 1'b1, 1'b0);
    issue(OP_TCP, 2'b00, 3'b000, 3, 3, 1'b0);
    chk_flags("tcp_eq", 1'b0, 1'b0);
    issue(OP_TGT, 2'b00, 3'b000, 5, 2, 1'b0);
    chk_flags("tgt", 1'b1, 1'b0);
    issue(OP_MOV, 2'b10, 3'b010, 11, 0, 1'b0);
    push_wr(7, ADDR_P1); issue(OP_MOV, 2'b01, 3'b011, 7, 0, 1'b0);
    issue(OP_TCP, 2'b00, 3'b000, 9, -9, 1'b0);
    chk_flags("tcp_gt", 1'b1, 1'b0);
    issue(OP_TEQ, 2'b00, 3'b000, 4, 5, 1'b0);
    chk_flags("teq", 1'b0, 1'b1);
    push_wr(-3, ADDR_P0);  issue(OP_MOV, 2'b10, 3'b010, -3, 0, 1'b0);
    push_wr(8, ADDR_ACC);  issue(OP_MOV, 2'b11, 3'b000, 8, 0, 1'b0);

    // Sleep 3 with a tick in the accept cycle; issue held valid but must not be taken
    issue(OP_SLP, 2'b00, 3'b000, 3, 0, 1'b1);
    chk("slp3_sleeping", 32'(sleeping), 32'(1));
    opcode = OP_MOV; cond = 2'b00; src0 = 11'(55); issue_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      repeat (2) @(posedge clk);
      #1;
      chk("slp3_gap_ready", 32'(issue_ready), 32'(0));
      @(negedge clk) tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      if (k == 3) issue_valid = 1'b0;
      chk("slp3_tick_ready", 32'(issue_ready), 32'((k == 3) ? 1 : 0));
      chk("slp3_tick_sleeping", 32'(sleeping), 32'((k == 3) ? 0 : 1));
    end

    issue(OP_SLP, 2'b00, 3'b000, 0, 0, 1'b0);
    chk("slp0_ready", 32'(issue_ready), 32'(1));
    issue(OP_SLP, 2'b00, 3'b000, -5, 0, 1'b0);
    chk("slpneg_ready", 32'(issue_ready), 32'(1));
    chk("slpneg_sleeping", 32'(sleeping), 32'(0));

    // Reserved opcode and skipped SLP
    issue(4'd13, 2'b00, 3'b000, 77, 77, 1'b0);
    chk_flags("rsvd", 1'b0, 1'b1);
    chk("rsvd_ready", 32'(issue_ready), 32'(1));
    issue(OP_SLP, 2'b01, 3'b000, 4, 0, 1'b0);
    chk("skipslp_ready", 32'(issue_ready), 32'(1));
    chk("skipslp_sleeping", 32'(sleeping), 32'(0));
    chk_flags("skipslp", 1'b0, 1'b1);

    // Ticks while idle have no effect
    repeat (2) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
    chk("idletick_ready", 32'(issue_ready), 32'(1));

    repeat (3) @(posedge clk);
    #1;
    chk("pending_writes", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
